fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer; slot0 is always the head entry.
module fetch_fifo #(
    parameter int unsigned W = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign count   = cnt;
    assign dout    = slot0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            cnt   <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) slot0 <= din;
                    else             slot1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues synchronous memory reads,
// buffers responses in a 2-entry FIFO and handles branch redirects.
module fetch_stage #(
    parameter int unsigned       ADDR_W   = fetch_pkg::ADDR_W,
    parameter int unsigned       DATA_W   = fetch_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              br_take,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [8:0]        br_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    import fetch_pkg::*;

    fetch_state_e             state_q;
    logic [ADDR_W-1:0]        pc_q;
    logic [ADDR_W-1:0]        req_addr_q;
    logic                     inflight_q;
    logic [ADDR_W-1:0]        target;
    logic                     pop;
    logic                     push;
    logic                     issue;
    logic [2:0]               occ;
    logic [2:0]               lim;
    logic [1:0]               fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [DATA_W+ADDR_W-1:0] head;

    assign target = br_pc + ADDR_W'($signed(br_offset));

    // Issue only if the slot freed by this cycle's pop leaves room for the reply.
    assign pop   = out_valid && out_ready;
    assign occ   = {1'b0, fifo_count} + {2'b0, inflight_q};
    assign lim   = 3'd2 + {2'b0, pop};
    assign issue = fetch_en && (state_q == ST_FETCH) && !br_take && (occ < lim);
    assign push  = inflight_q && !br_take && (!fifo_full || pop);

    assign imem_en   = issue;
    assign imem_addr = pc_q;
    assign out_valid = !fifo_empty;
    assign out_instr = head[ADDR_W +: DATA_W];
    assign out_pc    = head[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) req_addr_q <= pc_q;
            if (br_take) begin
                pc_q    <= target;
                state_q <= ST_FLUSH;
            end else begin
                if (issue) pc_q <= pc_q + ADDR_W'(1);
                case (state_q)
                    ST_BOOT:  state_q <= ST_FETCH;
                    ST_FLUSH: state_q <= ST_FETCH;
                    default:  state_q <= state_q;
                endcase
            end
        end
    end

    fetch_fifo #(
        .W (DATA_W + ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (br_take),
        .din   ({imem_rdata, req_addr_q}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
